// File: rtl/chan_mux_pkg.sv
// Shared constants and helpers for the channel multiplexer.
package chan_mux_pkg;

  localparam logic MODE_SEL = 1'b0;  // forward the channel named by sel
  localparam logic MODE_RR  = 1'b1;  // rotate fairly over valid channels

  // Width of a channel id; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping,
// with ptr itself examined last.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                grant_valid,
  output logic [SEL_W-1:0]    grant_idx
);

  localparam int NPOW = 1 << SEL_W;

  // Zero-extended so any SEL_W-wide index is in range.
  logic [NPOW-1:0] req_ext;
  assign req_ext = NPOW'(req);

  // Scan the ring from the farthest candidate to the nearest; the nearest
  // valid one is written last and therefore wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand = SEL_W'((int'(ptr) + k) % CHANNELS);
      if (req_ext[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/chan_mux.sv
// N-to-1 channel multiplexer with a one-word output register, explicit or
// round-robin selection, and valid/ready handshakes on every port.
module chan_mux
  import chan_mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int NPOW = 1 << SEL_W;

  logic [CHANNELS-1:0][WIDTH-1:0] lanes;
  logic [NPOW-1:0]                vld_ext;
  logic [SEL_W-1:0]               ptr;
  logic                           rr_gv;
  logic [SEL_W-1:0]               rr_idx;
  logic                           gnt_vld;
  logic [SEL_W-1:0]               gnt_idx;
  logic                           loadable;
  logic                           xfer;
  logic [WIDTH-1:0]               gnt_data;

  assign lanes   = in_data;
  // Padding bits are zero, so a sel beyond the last channel never grants.
  assign vld_ext = NPOW'(in_valid);

  rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_rr (
    .req         (in_valid),
    .ptr         (ptr),
    .grant_valid (rr_gv),
    .grant_idx   (rr_idx)
  );

  // Pick the grant for this cycle and whether the output register can take it.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    loadable = !out_valid || out_ready;
    if (mode == MODE_RR) begin
      gnt_vld = rr_gv;
      gnt_idx = rr_idx;
    end else begin
      gnt_vld = vld_ext[sel];
      gnt_idx = sel;
    end
  end

  assign xfer = !rst && loadable && gnt_vld;

  // One-hot ready to the granted source, plus the matching data word.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        gnt_data    = lanes[i];
      end
    end
  end

  // Output register: load on transfer, drop valid when drained with no new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer follows every accepted channel; reset points at the
  // last channel so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst)       ptr <= SEL_W'(CHANNELS - 1);
    else if (xfer) ptr <= gnt_idx;
  end

endmodule
